// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
package mips_pkg;

   localparam int unsigned XLEN = 32;

   typedef logic [XLEN-1:0] word_t;

   localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
   localparam word_t NOP_INSTR        = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD,
      DRAIN
   } fetch_state_e;

   // One IF/ID entry: the instruction plus its PC and fall-through PC.
   typedef struct packed {
      word_t instr;
      word_t pc;
      word_t pc4;
   } if_id_t;

   function automatic word_t word_align(input word_t addr);
      return addr & ~word_t'(3);
   endfunction

endpackage

// File: rtl/mips_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory handshake, decode control and IF/ID outputs.
interface mips_fetch_stage_if;
   import mips_pkg::*;

   logic  imem_req;
   word_t imem_addr;
   logic  imem_ack;
   word_t imem_rdata;
   logic  id_stall;
   logic  redirect_valid;
   word_t redirect_pc;
   logic  if_id_valid;
   word_t if_id_instr;
   word_t if_id_pc;
   word_t if_id_pc4;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata,
      input  id_stall,
      input  redirect_valid,
      input  redirect_pc,
      output if_id_valid,
      output if_id_instr,
      output if_id_pc,
      output if_id_pc4
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata,
      output id_stall,
      output redirect_valid,
      output redirect_pc,
      input  if_id_valid,
      input  if_id_instr,
      input  if_id_pc,
      input  if_id_pc4
   );

endinterface

// File: rtl/mips_if_id_reg.sv
// IF/ID pipeline register with a one-entry skid that catches a word acked
// while decode is stalled.
module mips_if_id_reg
   import mips_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load_fetch_i,
   input  logic   load_skid_i,
   input  logic   skid_wr_i,
   input  logic   flush_i,
   input  logic   consume_i,
   input  word_t  fetch_instr_i,
   input  word_t  fetch_pc_i,
   output logic   valid_o,
   output if_id_t data_o
);

   if_id_t slot_q, slot_d;
   if_id_t skid_q, skid_d;
   logic   valid_q, valid_d;
   logic   skid_valid_q, skid_valid_d;
   if_id_t fetch_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q       <= '{instr: NOP_INSTR, pc: '0, pc4: '0};
         skid_q       <= '{instr: NOP_INSTR, pc: '0, pc4: '0};
         valid_q      <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         slot_q       <= slot_d;
         skid_q       <= skid_d;
         valid_q      <= valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   // Later assignments take priority: flush overrides every load.
   always_comb begin
      fetch_word.instr = fetch_instr_i;
      fetch_word.pc    = fetch_pc_i;
      fetch_word.pc4   = fetch_pc_i + 32'd4;
      slot_d           = slot_q;
      skid_d           = skid_q;
      valid_d          = valid_q;
      skid_valid_d     = skid_valid_q;
      if (consume_i) begin
         valid_d = 1'b0;
      end
      if (skid_wr_i) begin
         skid_d       = fetch_word;
         skid_valid_d = 1'b1;
      end
      if (load_fetch_i) begin
         slot_d  = fetch_word;
         valid_d = 1'b1;
      end
      if (load_skid_i) begin
         slot_d       = skid_q;
         valid_d      = skid_valid_q;
         skid_valid_d = 1'b0;
      end
      if (flush_i) begin
         valid_d      = 1'b0;
         skid_valid_d = 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = slot_q;

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction fetch stage: owns the PC, runs the imem req/ack handshake and
// feeds decode through the IF/ID register, honouring stalls and redirects.
module mips_fetch_stage
   import mips_pkg::*;
#(
   parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   mips_fetch_stage_if.master fetch_bus
);

   fetch_state_e state_q, state_d;
   word_t        pc_q, pc_d;
   word_t        target_q, target_d;
   word_t        redirect_tgt;
   logic         slot_free;
   logic         load_fetch;
   logic         load_skid;
   logic         skid_wr;
   logic         flush;
   logic         if_id_valid;
   if_id_t       if_id_data;

   assign redirect_tgt = word_align(fetch_bus.redirect_pc);
   assign slot_free    = !if_id_valid || !fetch_bus.id_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         target_q <= RESET_PC;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         target_q <= target_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      target_d   = target_q;
      load_fetch = 1'b0;
      load_skid  = 1'b0;
      skid_wr    = 1'b0;
      flush      = 1'b0;
      unique case (state_q)
         IDLE: begin
            state_d = REQ;
         end
         REQ: begin
            if (fetch_bus.redirect_valid) begin
               flush = 1'b1;
               if (fetch_bus.imem_ack) begin
                  pc_d = redirect_tgt;
               end else begin
                  // Memory still owns the old request; finish it before switching.
                  target_d = redirect_tgt;
                  state_d  = DRAIN;
               end
            end else if (fetch_bus.imem_ack) begin
               pc_d = pc_q + 32'd4;
               if (slot_free) begin
                  load_fetch = 1'b1;
               end else begin
                  skid_wr = 1'b1;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (fetch_bus.redirect_valid) begin
               flush   = 1'b1;
               pc_d    = redirect_tgt;
               state_d = REQ;
            end else if (!fetch_bus.id_stall) begin
               load_skid = 1'b1;
               state_d   = REQ;
            end
         end
         DRAIN: begin
            if (fetch_bus.redirect_valid) begin
               flush    = 1'b1;
               target_d = redirect_tgt;
            end
            if (fetch_bus.imem_ack) begin
               pc_d    = fetch_bus.redirect_valid ? redirect_tgt : target_q;
               state_d = REQ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign fetch_bus.imem_req  = (state_q == REQ) || (state_q == DRAIN);
   assign fetch_bus.imem_addr = pc_q;

   mips_if_id_reg u_if_id (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_fetch_i  (load_fetch),
      .load_skid_i   (load_skid),
      .skid_wr_i     (skid_wr),
      .flush_i       (flush),
      .consume_i     (!fetch_bus.id_stall),
      .fetch_instr_i (fetch_bus.imem_rdata),
      .fetch_pc_i    (pc_q),
      .valid_o       (if_id_valid),
      .data_o        (if_id_data)
   );

   assign fetch_bus.if_id_valid = if_id_valid;
   assign fetch_bus.if_id_instr = if_id_data.instr;
   assign fetch_bus.if_id_pc    = if_id_data.pc;
   assign fetch_bus.if_id_pc4   = if_id_data.pc4;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Scoreboard bench for mips_fetch_stage: a random memory/decode driver pushes
// the expected program-order stream, a negedge monitor pops and compares.
module tb_mips_fetch_stage;
   import mips_pkg::*;

   localparam word_t KEY = 32'hA5A5_0000;

   logic clk;
   logic rst_n;

   mips_fetch_stage_if bus ();

   mips_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fetch_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int pops   = 0;

   // Reference model: the address the program expects next, and any redirect
   // target still waiting for an outstanding request to be acknowledged.
   if_id_t exp_q[$];
   word_t  want = '0;
   bit     pend;
   word_t  pend_tgt;

   bit    drv_en;
   int    ack_pct, stall_pct, redir_pct;
   bit    os_valid, os_ack, os_stall, os_redir;
   word_t os_tgt;

   bit    d_ack, d_stall, d_redir;
   word_t d_tgt;

   bit    ev_push, ev_drain;
   word_t ev_push_pc, ev_drain_tgt;

   bit    h_valid, h_req, h_ack, h_redir, h_stall, h_ifv, h_push, h_drain;
   word_t h_addr, h_tgt, h_push_pc, h_drain_tgt;

   task automatic check(input string name, input word_t act, input word_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic run(input int a, input int s, input int r, input int n);
      ack_pct   = a;
      stall_pct = s;
      redir_pct = r;
      repeat (n) @(negedge clk);
   endtask

   task automatic oneshot(input bit a, input bit s, input bit r, input word_t t);
      os_ack   = a;
      os_stall = s;
      os_redir = r;
      os_tgt   = t;
      os_valid = 1'b1;
      @(negedge clk);
   endtask

   // Driver: memory responder plus decode stall/redirect source.
   initial begin
      bus.imem_ack       = 1'b0;
      bus.imem_rdata     = '0;
      bus.id_stall       = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      forever begin
         @(posedge clk);
         #1;
         ev_push  = 1'b0;
         ev_drain = 1'b0;
         d_ack    = 1'b0;
         d_stall  = 1'b0;
         d_redir  = 1'b0;
         d_tgt    = '0;
         if (!rst_n) begin
            exp_q.delete();
            want = 32'h0000_0000;
            pend = 1'b0;
         end else if (drv_en) begin
            if (os_valid) begin
               d_ack    = os_ack;
               d_stall  = os_stall;
               d_redir  = os_redir;
               d_tgt    = os_tgt;
               os_valid = 1'b0;
            end else begin
               d_ack   = int'($urandom_range(99)) < ack_pct;
               d_stall = int'($urandom_range(99)) < stall_pct;
               d_redir = int'($urandom_range(99)) < redir_pct;
               d_tgt   = $urandom;
               // Keep a redirect target distinct from an outstanding request address.
               if (d_redir && bus.imem_req && ((d_tgt & ~32'd3) == bus.imem_addr))
                  d_tgt = d_tgt ^ 32'h40;
            end
            d_ack = d_ack && bus.imem_req;
         end
         bus.imem_ack       = d_ack;
         bus.imem_rdata     = d_ack ? (bus.imem_addr ^ KEY) : $urandom;
         bus.id_stall       = d_stall;
         bus.redirect_valid = d_redir;
         bus.redirect_pc    = d_tgt;
         if (rst_n && drv_en) begin
            if (d_redir) begin
               exp_q.delete();
               want     = d_tgt & ~32'd3;
               pend     = bus.imem_req && !d_ack;
               pend_tgt = want;
            end else if (d_ack) begin
               if (pend) begin
                  ev_drain     = 1'b1;
                  ev_drain_tgt = pend_tgt;
                  pend         = 1'b0;
               end else begin
                  if_id_t e;
                  check("fetch_addr", bus.imem_addr, want);
                  e.instr = want ^ KEY;
                  e.pc    = want;
                  e.pc4   = want + 32'd4;
                  exp_q.push_back(e);
                  ev_push    = 1'b1;
                  ev_push_pc = want;
                  want       = want + 32'd4;
               end
            end
         end
      end
   end

   // Monitor: timing rules against the previous cycle, and in-order delivery.
   initial begin
      h_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            h_valid = 1'b0;
            continue;
         end
         if (h_valid) begin
            if (h_req && !h_ack) begin
               check("req_held", word_t'(bus.imem_req), 32'd1);
               check("addr_stable", bus.imem_addr, h_addr);
            end
            if (h_redir) begin
               check("flush_valid", word_t'(bus.if_id_valid), 32'd0);
               if (!h_req || h_ack) begin
                  check("redir_req", word_t'(bus.imem_req), 32'd1);
                  check("redir_addr", bus.imem_addr, h_tgt & ~32'd3);
               end
            end
            if (h_push) begin
               if (!h_ifv || !h_stall) begin
                  check("latency_valid", word_t'(bus.if_id_valid), 32'd1);
                  check("latency_pc", bus.if_id_pc, h_push_pc);
               end else begin
                  check("hold_req_low", word_t'(bus.imem_req), 32'd0);
               end
            end
            if (h_drain) begin
               check("drain_req", word_t'(bus.imem_req), 32'd1);
               check("drain_addr", bus.imem_addr, h_drain_tgt);
            end
         end
         if (bus.if_id_valid && !bus.id_stall && !bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL deliver: got pc %h, expected no word (t=%0t)", bus.if_id_pc, $time);
            end else begin
               if_id_t e;
               e = exp_q.pop_front();
               check("instr", bus.if_id_instr, e.instr);
               check("pc", bus.if_id_pc, e.pc);
               check("pc4", bus.if_id_pc4, e.pc4);
               pops++;
               $display("txn pc=%h instr=%h pc4=%h", bus.if_id_pc, bus.if_id_instr, bus.if_id_pc4);
            end
         end
         h_valid     = 1'b1;
         h_req       = bus.imem_req;
         h_ack       = bus.imem_ack;
         h_redir     = bus.redirect_valid;
         h_stall     = bus.id_stall;
         h_ifv       = bus.if_id_valid;
         h_addr      = bus.imem_addr;
         h_tgt       = bus.redirect_pc;
         h_push      = ev_push;
         h_push_pc   = ev_push_pc;
         h_drain     = ev_drain;
         h_drain_tgt = ev_drain_tgt;
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_req"}, word_t'(bus.imem_req), 32'd0);
      check({tag, "_addr"}, bus.imem_addr, 32'h0000_0000);
      check({tag, "_valid"}, word_t'(bus.if_id_valid), 32'd0);
      check({tag, "_instr"}, bus.if_id_instr, 32'd0);
      check({tag, "_pc"}, bus.if_id_pc, 32'd0);
      check({tag, "_pc4"}, bus.if_id_pc4, 32'd0);
   endtask

   initial begin
      drv_en   = 1'b0;
      os_valid = 1'b0;
      rst_n    = 1'b0;
      run(0, 0, 0, 0);
      #12;
      check_reset_values("reset");

      @(negedge clk);
      rst_n = 1'b1;
      check("idle_req", word_t'(bus.imem_req), 32'd0);
      @(posedge clk);
      #2;
      check("first_req", word_t'(bus.imem_req), 32'd1);
      check("first_addr", bus.imem_addr, 32'h0000_0000);
      drv_en = 1'b1;

      // Zero-wait, no stall: one word per cycle.
      run(100, 0, 0, 20);
      repeat (8) begin
         @(negedge clk);
         check("throughput", word_t'(bus.if_id_valid), 32'd1);
      end

      // Delayed ack, then decode stall of 5 cycles.
      run(0, 0, 0, 3);
      run(100, 0, 0, 5);
      run(100, 100, 0, 5);
      run(100, 0, 0, 5);

      // Redirect with simultaneous ack and stall: acked data dropped.
      oneshot(1'b1, 1'b1, 1'b1, 32'h0000_0103);
      run(100, 0, 0, 6);

      // Redirect while the request is unacknowledged: drain then refetch.
      run(0, 0, 0, 2);
      oneshot(1'b0, 1'b0, 1'b1, 32'h0000_0200);
      run(0, 0, 0, 2);
      run(100, 0, 0, 6);

      // Random traffic.
      run(60, 30, 5, 3000);

      // PC wrap through 0xFFFF_FFFC.
      run(100, 0, 0, 3);
      oneshot(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFA);
      run(100, 0, 0, 6);

      // Park a request at 0xFFFF_FFFC with IF/ID held, then reset mid-wait.
      oneshot(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF3);
      run(100, 0, 0, 3);
      run(0, 100, 0, 3);
      check("park_addr", bus.imem_addr, 32'hFFFF_FFFC);
      check("park_valid", word_t'(bus.if_id_valid), 32'd1);
      check("park_pc4", bus.if_id_pc4, 32'hFFFF_FFFC);
      @(posedge clk);
      #3;
      drv_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check_reset_values("async_reset");
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      drv_en = 1'b1;
      pops   = 0;

      run(100, 0, 0, 20);
      run(0, 0, 0, 4);
      check("queue_empty", word_t'(exp_q.size()), 32'd0);
      check("progress", word_t'(pops >= 15), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
